alu: RTL and testbench

- Parameterised two-operand ALU with registered outputs.
- Supports AND, XOR, ADD and SUB, with carry and status flags.
- Sits in the datapath as a single-cycle-latency compute stage with a simple valid qualifier.
- Consumers sample the result and flags one clock after the operands are presented.

---
 rtl/alu_if.sv | 21 ++
 rtl/alu.sv | 49 ++++
 tb/tb_alu.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// alu_if: operand/result bus between a datapath producer and the ALU stage
interface alu_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] o;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             out_valid;
  modport master (
    output in_valid, op, i0, i1,
    input  o, cout, zero, neg, ovf, out_valid
  );
  modport slave (
    input  in_valid, op, i0, i1,
    output o, cout, zero, neg, ovf, out_valid
  );
endinterface

// File: rtl/alu.sv
// alu: two-operand AND/XOR/ADD/SUB stage with registered result, carry and flags
module alu #(parameter int WIDTH = 8) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  logic [WIDTH-1:0] o_q, o_d, b, res;
  logic [WIDTH:0]   sum;
  logic             arith;
  logic             cout_q, cout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic             valid_q, valid_d;
  // SUB reuses the adder as i0 + ~i1 + 1; op[0] selects both the inversion and the carry-in
  always_comb begin
    arith   = bus.op[1];
    b       = bus.op[0] ? ~bus.i1 : bus.i1;
    sum     = {1'b0, bus.i0} + {1'b0, b} + {{WIDTH{1'b0}}, bus.op[0]};
    res     = arith ? sum[WIDTH-1:0] : bus.op[0] ? bus.i0 ^ bus.i1 : bus.i0 & bus.i1;
    valid_d = bus.in_valid;
    o_d     = bus.in_valid ? res : o_q;
    cout_d  = bus.in_valid ? arith & sum[WIDTH] : cout_q;
    zero_d  = bus.in_valid ? res == '0 : zero_q;
    neg_d   = bus.in_valid ? res[WIDTH-1] : neg_q;
    ovf_d   = bus.in_valid ? arith & (bus.i0[WIDTH-1] == b[WIDTH-1]) & (res[WIDTH-1] != bus.i0[WIDTH-1]) : ovf_q;
  end
  // output registers; reset clears everything and reports a zero result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end
  assign bus.o         = o_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed checks of the alu against an arithmetic reference model
module tb_alu;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [W+4:0] got, exp_v;
  alu_if #(.WIDTH(W)) bus();
  alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign got = {bus.o, bus.cout, bus.zero, bus.neg, bus.ovf, bus.out_valid};
  localparam logic [W+4:0] RST_V = {{W{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  // reference: integer arithmetic, carry/overflow judged by range checks
  function automatic logic [W+4:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, sa, sb, r, sr, smax, smin;
    logic c, v;
    logic [W-1:0] res;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      2'b00: r = ua & ub;
      2'b01: r = ua ^ ub;
      2'b10: begin
        r = ua + ub;
        c = r >= (longint'(1) << W);
        sr = sa + sb;
        v = sr > smax || sr < smin;
      end
      default: begin
        r = ua - ub;
        c = ua >= ub;
        sr = sa - sb;
        v = sr > smax || sr < smin;
      end
    endcase
    res = r[W-1:0];
    return {res, c, res == '0, res[W-1], v, 1'b1};
  endfunction
  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = v;
    bus.op = op;
    bus.i0 = a;
    bus.i1 = b;
  endtask
  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if (got !== RST_V) begin
      miscompares++;
      $display("FAIL reset_hold got=%h want=%h", got, RST_V);
    end
    rst_n = 1'b1;
    drive(1'b1, 2'b10, 8'h7F, 8'h01);
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (got !== RST_V) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=%h", got, RST_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_directed;
    logic [1:0]   ops [10] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
    logic [W-1:0] as  [10] = '{8'hCC, 8'hCC, 8'h0F, 8'hFF, 8'h7F, 8'hF0, 8'h0F, 8'h80, 8'h55, 8'h80};
    logic [W-1:0] bs  [10] = '{8'hAA, 8'hAA, 8'h0F, 8'h01, 8'h01, 8'h0F, 8'hF0, 8'h01, 8'h55, 8'h80};
    logic [W-1:0] eo  [10] = '{8'h88, 8'h66, 8'h1E, 8'h00, 8'h80, 8'hE1, 8'h1F, 8'h7F, 8'h00, 8'h00};
    logic         ec  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         ev  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      @(negedge clk);
      exp_v = model(ops[i], as[i], bs[i]);
      vectors++;
      if (got !== exp_v || bus.o !== eo[i] || bus.cout !== ec[i] || bus.ovf !== ev[i]) begin
        miscompares++;
        $display("FAIL directed_%0d got=%h want=%h (o=%h cout=%b ovf=%b)", i, got, exp_v, eo[i], ec[i], ev[i]);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [W-1:0] last_o;
    logic [W+4:0] last;
    logic [1:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 3; i++) begin
      op = 2'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      drive(1'b1, op, a, b);
      @(negedge clk);
      last = model(op, a, b);
      vectors++;
      if (got !== last) begin
        miscompares++;
        $display("FAIL b2b_%0d got=%h want=%h", i, got, last);
      end
    end
    last_o = last[W+4:5];
    bus.in_valid = 1'b0;
    bus.op = 'x;
    bus.i0 = 'x;
    bus.i1 = 'x;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (got !== {last[W+4:1], 1'b0} || bus.o !== last_o) begin
        miscompares++;
        $display("FAIL hold_%0d got=%h want=%h", i, got, {last[W+4:1], 1'b0});
      end
    end
  endtask
  task automatic test_reset_inflight;
    drive(1'b1, 2'b11, 8'h12, 8'h34);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (got !== RST_V) begin
      miscompares++;
      $display("FAIL inflight_reset got=%h want=%h", got, RST_V);
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (got !== RST_V) begin
        miscompares++;
        $display("FAIL post_reset_idle_%0d got=%h want=%h", i, got, RST_V);
      end
    end
    drive(1'b1, 2'b11, 8'h12, 8'h34);
    @(negedge clk);
    exp_v = model(2'b11, 8'h12, 8'h34);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL first_after_reset got=%h want=%h", got, exp_v);
    end
  endtask
  task automatic test_random;
    logic [W+4:0] held;
    logic v;
    logic [1:0] op;
    logic [W-1:0] a, b;
    held = got;
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 3) != 0;
      op = 2'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      if (i % 7 == 0) a = (i % 2 == 0) ? 8'h80 : 8'h7F;
      drive(v, op, a, b);
      @(negedge clk);
      held = v ? model(op, a, b) : {held[W+4:1], 1'b0};
      vectors++;
      if (got !== held) begin
        miscompares++;
        $display("FAIL random_%0d op=%b a=%h b=%h v=%b got=%h want=%h", i, op, a, b, v, got, held);
      end
    end
  endtask
  initial begin
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_inflight;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
